// File: rtl/z_stage_pkg.sv
// z_stage_pkg
// Shared definitions for the Z result stage: op encodings, the sequencer
// state enum and the Z register width.
package z_stage_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int Z_WIDTH   = 2 * WIDTH_DEF;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } z_state_e;

endpackage

// File: rtl/z_booth_core.sv
// z_booth_core
// Radix-2 Booth multiplier register and step datapath.
//   i_clk, i_rst    : clock, asynchronous active-high reset (clears everything)
//   i_load          : capture multiplicand/multiplier, clear accumulator
//   i_step          : perform one Booth add/sub + arithmetic right shift
//   i_mcand, i_mplier : signed operands
//   o_product       : 2*WIDTH-bit product as it will be AFTER the current step,
//                     so the sequencer can latch it on the final step edge
module z_booth_core #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_product
);

  // Accumulator and multiplicand are one bit wider so that subtracting the
  // most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   r_m;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic             r_qm1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
    // Arithmetic right shift of the whole {acc, q, q_-1} register.
    w_acc_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
  end

  assign o_product = {w_acc_nxt[WIDTH-1:0], w_q_nxt};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m   <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_qm1 <= 1'b0;
    end else if (i_load) begin
      r_m   <= {i_mcand[WIDTH-1], i_mcand};
      r_acc <= '0;
      r_q   <= i_mplier;
      r_qm1 <= 1'b0;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_qm1 <= r_q[0];
    end
  end

endmodule

// File: rtl/z_result_stage.sv
// z_result_stage
// Result stage behind the ALU gates; owns the 64-bit Z register pair.
//   clk, clr    : clock, asynchronous active-high reset
//   start, op   : request and opcode (PASS / MUL / DIV / reserved)
//   a, b        : signed operands for MUL / DIV
//   gate_result : combinational ALU gate output latched by PASS
//   busy, done  : multi-cycle activity, one-cycle completion pulse
//   zhi, zlo    : Z high / low word
// Optional feature macro: ZSTAGE_DIV_EN enables the iterative signed divide;
// without it op=DIV behaves like the reserved op.
//
// Handshake: start is sampled on a rising edge only while the state is IDLE;
// otherwise it is dropped (no queueing). Every accepted request produces
// exactly one done pulse, in the cycle during which the new Z is visible.
// PASS and reserved ops complete in the cycle after acceptance; MUL/DIV
// complete WIDTH+1 cycles after acceptance with busy high in between.
module z_result_stage
  import z_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] gate_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zhi,
  output logic [WIDTH-1:0] zlo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  z_state_e         r_state;
  z_state_e         w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_zhi;
  logic [WIDTH-1:0] r_zlo;

  logic             w_div_op;
  logic             w_launch;
  logic             w_short;
  logic             w_step;
  logic             w_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_z_final;

`ifdef ZSTAGE_DIV_EN
  assign w_div_op = (op == OP_DIV);
`else
  assign w_div_op = 1'b0;
`endif

  // Sequencer: next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_short     = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL || w_div_op) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_short = 1'b1;
          end
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_last      = 1'b1;
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  z_booth_core #(.WIDTH(WIDTH)) u_booth (
    .i_clk     (clk),
    .i_rst     (clr),
    .i_load    (w_launch & ~w_div_op),
    .i_step    (w_step),
    .i_mcand   (a),
    .i_mplier  (b),
    .o_product (w_prod)
  );

`ifdef ZSTAGE_DIV_EN
  // Restoring divide on magnitudes; r_div_quo starts as |dividend| and is
  // shifted out MSB-first into the partial remainder while quotient bits
  // shift in at the bottom.
  logic             r_is_div;
  logic             r_div_neg_q;
  logic             r_div_neg_r;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_dvs;
  logic [WIDTH-1:0] r_div_rem;
  logic [WIDTH-1:0] r_div_quo;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_res;
  logic [WIDTH-1:0] w_rem_res;

  always_comb begin
    w_rem_sh  = {r_div_rem, r_div_quo[WIDTH-1]};
    w_diff    = w_rem_sh - {1'b0, r_div_dvs};
    w_ge      = ~w_diff[WIDTH];
    w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_nxt = {r_div_quo[WIDTH-2:0], w_ge};
    // Divide by zero is forced to all-ones / dividend; most-negative / -1
    // falls out naturally because negating 2^(WIDTH-1) wraps to itself.
    if (r_div_zero) begin
      w_quo_res = '1;
      w_rem_res = r_div_a;
    end else begin
      w_quo_res = r_div_neg_q ? -w_quo_nxt : w_quo_nxt;
      w_rem_res = r_div_neg_r ? -w_rem_nxt : w_rem_nxt;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_is_div    <= 1'b0;
      r_div_neg_q <= 1'b0;
      r_div_neg_r <= 1'b0;
      r_div_zero  <= 1'b0;
      r_div_a     <= '0;
      r_div_dvs   <= '0;
      r_div_rem   <= '0;
      r_div_quo   <= '0;
    end else if (w_launch) begin
      r_is_div    <= w_div_op;
      r_div_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      r_div_neg_r <= a[WIDTH-1];
      r_div_zero  <= (b == '0);
      r_div_a     <= a;
      r_div_dvs   <= b[WIDTH-1] ? -b : b;
      r_div_rem   <= '0;
      r_div_quo   <= a[WIDTH-1] ? -a : a;
    end else if (w_step && r_is_div) begin
      r_div_rem <= w_rem_nxt;
      r_div_quo <= w_quo_nxt;
    end
  end

  assign w_z_final = r_is_div ? {w_rem_res, w_quo_res} : w_prod;
`else
  assign w_z_final = w_prod;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_zhi  <= '0;
      r_zlo  <= '0;
    end else begin
      r_done <= w_short | w_last;
      if (w_launch)
        r_cnt <= CNT_INIT;
      else if (w_step && !w_last)
        r_cnt <= r_cnt - CW'(1);
      if (w_short && op == OP_PASS) begin
        r_zhi <= '0;
        r_zlo <= gate_result;
      end else if (w_last) begin
        {r_zhi, r_zlo} <= w_z_final;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign zhi  = r_zhi;
  assign zlo  = r_zlo;

endmodule
